// File: rtl/uart_rx_os16_pkg.sv
// rtl/uart_rx_os16_pkg.sv - shared UART constants and receiver state encoding
package uart_rx_os16_pkg;

  // Oversampling ratio shared by the receiver and the transmitter.
  localparam int OS_DEFAULT = 16;
  // 8N1 frame: start + 8 data + stop.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_os16_sync_ff.sv
// rtl/uart_rx_os16_sync_ff.sv - multi-flop synchronizer for the rxd line, resets to idle-high
module uart_rx_os16_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; reset to all ones so the line looks idle during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 8N1 UART receiver with OS-times oversampling and framing-error report
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int OS          = OS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_bd,
  input  logic       rxd,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (OS > 1) ? $clog2(OS) : 1;
  // Mid-point of the start bit and last tick of a full bit period.
  localparam logic [TW-1:0] TICK_MID  = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);

  logic            rxs;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      dataout_q, dataout_d;
  logic            rdsig_q, rdsig_d;
  logic            ferr_q, ferr_d;

  uart_rx_os16_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxs)
  );

  // State and datapath registers; pulses are registered so they last exactly one clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dataout_q <= '0;
      rdsig_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dataout_q <= dataout_d;
      rdsig_q   <= rdsig_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic; everything holds unless an oversample tick is present.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    dataout_d = dataout_q;
    rdsig_d   = 1'b0;
    ferr_d    = 1'b0;
    if (clk_bd) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_MID) begin
            // Line must still be low at mid start bit, otherwise it was a glitch.
            if (!rxs) begin
              state_d = ST_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxs) begin
              dataout_d = shift_q;
              rdsig_d   = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // Sit out a break until the line returns high.
          if (rxs) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign dataout   = dataout_q;
  assign rdsig     = rdsig_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - self-checking bench for uart_rx_os16
module tb_uart_rx_os16;

  localparam int OS     = 16;
  localparam int BD_DIV = 4;
  localparam int BITCLK = OS * BD_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_bd = 1'b0;
  logic       rxd;
  logic       rxd_drv = 1'b1;
  logic       tx_line = 1'b1;
  logic       loop_en = 1'b0;
  logic       wrsig = 1'b0;
  logic [7:0] datain = 8'h00;
  logic [7:0] dataout;
  logic       rdsig;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         got_ferr = 0;
  int         exp_ferr = 0;
  logic [7:0] exp_dout = 8'h00;
  logic       prev_r = 1'b0;
  logic       prev_f = 1'b0;
  int         bd_cnt = 0;
  logic [9:0] tx_bits;

  assign rxd = loop_en ? tx_line : rxd_drv;

  uart_rx_os16 #(
    .OS          (OS),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_bd    (clk_bd),
    .rxd       (rxd),
    .dataout   (dataout),
    .rdsig     (rdsig),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Oversample tick: one clk wide every BD_DIV clks.
  always @(negedge clk) begin
    if (bd_cnt == BD_DIV - 1) begin
      bd_cnt = 0;
      clk_bd = 1'b1;
    end else begin
      bd_cnt = bd_cnt + 1;
      clk_bd = 1'b0;
    end
  end

  // Behavioural transmitter used for the loopback case.
  always begin
    @(negedge clk);
    if (wrsig) begin
      tx_bits = {1'b1, datain, 1'b0};
      for (int i = 0; i < 10; i++) begin
        tx_line = tx_bits[i];
        repeat (BITCLK) @(negedge clk);
      end
      tx_line = 1'b1;
    end
  end

  // Collect received bytes and framing errors; pulses must be single and exclusive.
  always @(negedge clk) begin
    if (rdsig) got_q.push_back(dataout);
    if (frame_err) got_ferr = got_ferr + 1;
    if (rdsig || frame_err) begin
      checks = checks + 1;
      assert (!(rdsig && frame_err) && !(rdsig && prev_r) && !(frame_err && prev_f))
      else begin
        errors = errors + 1;
        $error("FAIL pulse_shape observed rdsig=%0b prev=%0b frame_err=%0b prev=%0b expected single exclusive pulses",
               rdsig, prev_r, frame_err, prev_f);
      end
    end
    prev_r = rdsig;
    prev_f = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame with a high stop bit delivers its byte, a low one a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = bits[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (stop) begin
      exp_q.push_back(b);
      exp_dout = b;
    end else begin
      exp_ferr = exp_ferr + 1;
    end
  endtask

  task automatic idle_bits(input int n);
    rxd_drv = 1'b1;
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_ferr"}, 32'(got_ferr), 32'(exp_ferr));
    check({tag, "_dataout"}, 32'(dataout), 32'(exp_dout));
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dataout", 32'(dataout), 32'h00);
    check("rst_rdsig", 32'(rdsig), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle_bits(1);

    // Single byte.
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    check("s1_busy", 32'(busy), 32'h0);
    compare_rx("s1");

    // Back-to-back frames, no idle bits in between.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    compare_rx("b2b");

    // Three-tick low glitch must be rejected at the start-bit midpoint.
    rxd_drv = 1'b0;
    repeat (3 * BD_DIV) @(negedge clk);
    rxd_drv = 1'b1;
    check("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (10 * BD_DIV) @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    idle_bits(1);
    compare_rx("glitch");

    // Low stop bit followed by a 20-bit break: one framing error only.
    send_frame(8'h81, 1'b0);
    repeat (20 * BITCLK) @(negedge clk);
    idle_bits(2);
    compare_rx("break");
    send_frame(8'h42, 1'b1);
    idle_bits(1);
    compare_rx("after_break");

    // Reset in the middle of data bit 4 of 0xFF.
    for (int i = 0; i < 5; i++) begin
      rxd_drv = (i == 0) ? 1'b0 : 1'b1;
      repeat (BITCLK) @(negedge clk);
    end
    repeat (BITCLK / 2) @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_rdsig", 32'(rdsig), 32'h0);
    check("mid_rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    exp_dout = 8'h00;
    idle_bits(6);
    compare_rx("reset");
    send_frame(8'h0F, 1'b1);
    idle_bits(1);
    compare_rx("after_reset");

    // Loopback from the behavioural transmitter.
    loop_en = 1'b1;
    datain = 8'hC3;
    wrsig = 1'b1;
    repeat (2) @(negedge clk);
    wrsig = 1'b0;
    repeat (11 * BITCLK) @(negedge clk);
    loop_en = 1'b0;
    exp_q.push_back(8'hC3);
    exp_dout = 8'hC3;
    compare_rx("loop");

    // Random bytes with random idle gaps of zero to two bits.
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      idle_bits(int'($urandom_range(0, 2)));
    end
    idle_bits(1);
    compare_rx("random");
    check("final_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
